// File: rtl/audio_i2s_out.sv
// PSG + PCM stereo mixer with saturation, and an I2S serialiser with a fixed
// 512-clk frame (BCK = clk/8, 64 BCK per frame, 32-bit slots, 16-bit data).
module audio_i2s_out (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic        mute,
  output logic        next_sample,
  output logic        i2s_lrck,
  output logic        i2s_bck,
  output logic        i2s_data
);

  // A 17-bit sum whose top two bits disagree has left the 16-bit signed range.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] res;
    sum = {a[15], a} + {b[15], b};
    case (sum[16:15])
      2'b01:   res = 16'h7FFF;
      2'b10:   res = 16'h8000;
      default: res = sum[15:0];
    endcase
    return res;
  endfunction

  logic [8:0]  cnt_r;
  logic [15:0] mix_l_r;
  logic [15:0] mix_r_r;
  logic [63:0] shift_r;
  logic        next_sample_r;

  logic        latch_s;
  logic        load_s;
  logic        shift_en_s;
  logic [15:0] mix_l_s;
  logic [15:0] mix_r_s;
  logic [63:0] frame_s;

  assign latch_s    = (cnt_r == 9'd510);
  assign load_s     = (cnt_r == 9'd511);
  assign shift_en_s = (cnt_r[2:0] == 3'd7) && !load_s;

  // Saturated mix, forced to silence when muted.
  always_comb begin
    mix_l_s = 16'h0000;
    mix_r_s = 16'h0000;
    if (mute) begin
      mix_l_s = 16'h0000;
      mix_r_s = 16'h0000;
    end else begin
      mix_l_s = sat_add16(psg_left, pcm_left);
      mix_r_s = sat_add16(psg_right, pcm_right);
    end
  end

  // Each 32-bit slot: one-BCK delay bit, 16 data bits MSB first, zero pad.
  assign frame_s = {1'b0, mix_l_r, 15'h0000, 1'b0, mix_r_r, 15'h0000};

  // Free-running frame counter; wraps 511 -> 0 with no gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 9'd0;
    end else begin
      cnt_r <= cnt_r + 9'd1;
    end
  end

  // Capture the mixed samples once per frame, one clk before frame load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_l_r <= 16'h0000;
      mix_r_r <= 16'h0000;
    end else if (latch_s) begin
      mix_l_r <= mix_l_s;
      mix_r_r <= mix_r_s;
    end else begin
      mix_l_r <= mix_l_r;
      mix_r_r <= mix_r_r;
    end
  end

  // Frame shift register: load at wrap, shift at the end of every BCK period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= 64'h0;
    end else if (load_s) begin
      shift_r <= frame_s;
    end else if (shift_en_s) begin
      shift_r <= {shift_r[62:0], 1'b0};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Sample strobe is high exactly while cnt is 511.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_sample_r <= 1'b0;
    end else begin
      next_sample_r <= latch_s;
    end
  end

  assign next_sample = next_sample_r;
  assign i2s_lrck    = cnt_r[8];
  assign i2s_bck     = cnt_r[2];
  assign i2s_data    = shift_r[63];

endmodule

// File: tb/tb_audio_i2s_out.sv
// Scoreboard bench for audio_i2s_out: stimulus pushes expected L/R words per
// frame, a monitor deserialises each frame and checks framing every clk.
module tb_audio_i2s_out;

  logic        clk;
  logic        rst;
  logic [15:0] psg_left, psg_right, pcm_left, pcm_right;
  logic        mute;
  logic        next_sample, i2s_lrck, i2s_bck, i2s_data;

  audio_i2s_out dut (
    .clk(clk), .rst(rst),
    .psg_left(psg_left), .psg_right(psg_right),
    .pcm_left(pcm_left), .pcm_right(pcm_right),
    .mute(mute),
    .next_sample(next_sample), .i2s_lrck(i2s_lrck),
    .i2s_bck(i2s_bck), .i2s_data(i2s_data)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int frames_done = 0;
  logic [31:0] exp_q[$];

  // Reference frame position: cycles since reset release, modulo 512.
  logic [8:0] tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 9'd0;
    else     tb_cnt <= tb_cnt + 9'd1;
  end

  task automatic fail_msg(input string name, input logic [63:0] got, input logic [63:0] want);
    failures++;
    if (failures <= 40)
      $display("FAIL %s at t=%0t pos=%0d: got 0x%0h, required 0x%0h", name, $time, tb_cnt, got, want);
  endtask

  // Monitor: framing checks every clk and whole-frame compare at frame end.
  logic        prev_data = 1'b0;
  logic [63:0] got_frame = 64'h0;
  always @(negedge clk) begin
    if (rst) begin
      prev_data = 1'b0;
    end else begin
      checks++;
      if (i2s_bck !== tb_cnt[2]) fail_msg("bck", {63'h0, i2s_bck}, {63'h0, tb_cnt[2]});
      checks++;
      if (i2s_lrck !== tb_cnt[8]) fail_msg("lrck", {63'h0, i2s_lrck}, {63'h0, tb_cnt[8]});
      checks++;
      if (next_sample !== (tb_cnt == 9'd511))
        fail_msg("next_sample", {63'h0, next_sample}, {63'h0, (tb_cnt == 9'd511)});
      if (tb_cnt[2:0] != 3'd0) begin
        checks++;
        if (i2s_data !== prev_data) fail_msg("data_stable", {63'h0, i2s_data}, {63'h0, prev_data});
      end
      prev_data = i2s_data;
      if (tb_cnt[2:0] == 3'd4) got_frame[63 - int'(tb_cnt[8:3])] = i2s_data;
      if (tb_cnt == 9'd511) begin
        checks++;
        if (exp_q.size() == 0) begin
          fail_msg("frame_no_expect", got_frame, 64'h0);
        end else begin
          logic [31:0] e;
          logic [63:0] want;
          e = exp_q.pop_front();
          want = {1'b0, e[31:16], 15'h0000, 1'b0, e[15:0], 15'h0000};
          if (got_frame !== want) fail_msg("frame", got_frame, want);
        end
        frames_done++;
      end
    end
  end

  typedef struct {
    logic [15:0] pl, pr, ql, qr;
    logic        m;
    logic [15:0] wpl, wpr, wql, wqr;
    logic        wm;
    logic [15:0] el, er;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_cnt(input logic [8:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (tb_cnt != target && n < 1100) begin
      @(negedge clk);
      n++;
    end
    if (tb_cnt != target) fail_msg("wait_timeout", {55'h0, tb_cnt}, {55'h0, target});
  endtask

  task automatic drive(input logic [15:0] pl, pr, ql, qr, input logic m);
    psg_left = pl; psg_right = pr; pcm_left = ql; pcm_right = qr; mute = m;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({next_sample, i2s_lrck, i2s_bck, i2s_data} !== 4'b0000)
      fail_msg(name, {60'h0, next_sample, i2s_lrck, i2s_bck, i2s_data}, 64'h0);
  endtask

  initial begin
    //        psg_l    psg_r    pcm_l    pcm_r    mute  window values (cnt=510)             mute  exp_l    exp_r
    vecs[0] = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'hABCD};
    vecs[1] = '{16'h7000, 16'h0100, 16'h7000, 16'hFF00, 1'b0, 16'h7000, 16'h0100, 16'h7000, 16'hFF00, 1'b0, 16'h7FFF, 16'h0000};
    vecs[2] = '{16'h8000, 16'hC000, 16'hFFFF, 16'hC000, 1'b0, 16'h8000, 16'hC000, 16'hFFFF, 16'hC000, 1'b0, 16'h8000, 16'h8000};
    vecs[3] = '{16'h5555, 16'h5555, 16'h5555, 16'h5555, 1'b0, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 16'h0F0F, 16'h0F0F};
    vecs[4] = '{16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vecs[5] = '{16'hFFFE, 16'h4000, 16'h0001, 16'h3FFF, 1'b0, 16'hFFFE, 16'h4000, 16'h0001, 16'h3FFF, 1'b0, 16'hFFFF, 16'h7FFF};
    vecs[6] = '{16'h00FF, 16'hFF00, 16'h0001, 16'h0000, 1'b1, 16'h00FF, 16'hFF00, 16'h0001, 16'h0000, 1'b0, 16'h0100, 16'hFF00};

    rst = 1'b1;
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    #1 rst = 1'b0;

    // Mid-frame asynchronous reset while lrck and bck are both high.
    wait_cnt(9'd301);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midframe_reset_immediate");
    repeat (3) @(negedge clk);
    check_outputs_zero("midframe_reset_held");
    exp_q.delete();
    frames_done = 0;
    #1 rst = 1'b0;
    exp_q.push_back(32'h0000_0000);

    foreach (vecs[i]) begin
      wait_cnt(9'd100);
      drive(vecs[i].pl, vecs[i].pr, vecs[i].ql, vecs[i].qr, vecs[i].m);
      exp_q.push_back({vecs[i].el, vecs[i].er});
      wait_cnt(9'd510);
      drive(vecs[i].wpl, vecs[i].wpr, vecs[i].wql, vecs[i].wqr, vecs[i].wm);
      wait_cnt(9'd511);
      drive(vecs[i].pl, vecs[i].pr, vecs[i].ql, vecs[i].qr, vecs[i].m);
    end

    for (int n = 0; n < 1200 && frames_done < 8; n++) @(negedge clk);
    checks++;
    if (frames_done < 8) fail_msg("frames_seen", 64'(frames_done), 64'd8);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
